fifo_uart_tx: RTL and testbench

//   Drain stage sitting directly downstream of the 8-bit fifo. Pops one byte when the

---
 rtl/fifo_uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drain stage for an 8-bit fifo. When enabled and the fifo holds data, it pops
//   one byte and sends it on a UART line: one start bit, eight data bits LSB
//   first, then STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT clocks.
//
// Ports
//   clk         in   system clock; all logic on posedge
//   rst         in   synchronous, active-high reset
//   enable      in   allows new frames; only looked at in IDLE and in the last
//                    stop-bit cycle
//   fifo_empty  in   fifo empty flag
//   fifo_data   in   fifo read data; valid the cycle after fifo_rd is high
//   fifo_rd     out  one-cycle pop strobe (registered)
//   tx          out  serial line, idles high (registered)
//   busy        out  high from FETCH through the end of the stop period
//   tx_done     out  one-cycle pulse in the first cycle after a completed frame
//   dbg_state   out  current FSM state encoding, for checkers and waveforms
//
// Handshake: the fifo side is a simple pop interface. A byte is popped only
// when enable && !fifo_empty in the deciding cycle (IDLE, or the last stop
// cycle). fifo_rd is then high for exactly one cycle (FETCH), and fifo_data
// is captured one cycle later (LOAD). No other cycle looks at the fifo.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'd7;
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  // Counts data bits in DATA and stop bits in STOP.
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          fifo_rd_q, fifo_rd_d;
  logic          busy_q, busy_d;
  logic          tx_done_q, tx_done_d;

  logic bit_end;
  logic start_ok;

  assign bit_end  = (clk_cnt_q == BIT_LAST);
  assign start_ok = enable && !fifo_empty;

  // Next-state and datapath.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        shift_d   = fifo_data;
        clk_cnt_d = '0;
        state_d   = S_START;
      end

      S_START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            tx_done_d = 1'b1;
            // Back-to-back: skip IDLE so only FETCH and LOAD sit between frames.
            state_d   = start_ok ? S_FETCH : S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    tx_d      = 1'b1;
    fifo_rd_d = (state_d == S_FETCH);
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      fifo_rd_q <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      fifo_rd_q <= fifo_rd_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx        = tx_q;
  assign fifo_rd   = fifo_rd_q;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Directed bench for fifo_uart_tx with CLKS_PER_BIT=4, STOP_BITS=1. A small
//   behavioural fifo sits upstream. Frames are checked sample by sample against
//   hand-written 10-bit frame patterns {stop, d7..d0, start}.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] dbg_state;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- upstream fifo model ----------------
  logic       push_req;
  logic [7:0] push_data;
  logic [7:0] fifo_mem[$];
  int         fifo_cnt = 0;

  initial fifo_data = 8'h00;

  always @(posedge clk) begin
    if (fifo_rd && fifo_mem.size() > 0) fifo_data <= fifo_mem.pop_front();
    if (push_req) fifo_mem.push_back(push_data);
    fifo_cnt <= fifo_mem.size();
  end

  assign fifo_empty = (fifo_cnt == 0);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    if (fifo_rd) rd_cnt++;
    if (tx_done) done_cnt++;
  endtask

  task automatic push(input logic [7:0] b);
    push_req  = 1'b1;
    push_data = b;
    tick();
    push_req  = 1'b0;
  endtask

  task automatic wait_rd(input string nm);
    int n = 0;
    while (!fifo_rd && n < 200) begin
      tick();
      n++;
    end
    check({nm, "_rd_seen"}, 32'(n < 200), 32'd1);
  endtask

  // Called with fifo_rd just sampled high. Checks LOAD, then 40 frame samples.
  task automatic frame_body(input logic [9:0] exp_f, input string nm,
                            input int drop_at, input int rst_at);
    int         d0;
    logic [7:0] dec;
    bit         aborted;
    d0      = done_cnt;
    dec     = 8'h00;
    aborted = 1'b0;
    tick();
    check({nm, "_load_tx"}, 32'(tx), 32'd1);
    check({nm, "_load_busy"}, 32'(busy), 32'd1);
    check({nm, "_load_rd"}, 32'(fifo_rd), 32'd0);
    for (int i = 0; i < 10 * CPB && !aborted; i++) begin
      tick();
      check($sformatf("%s_tx_s%0d", nm, i), 32'(tx), 32'(exp_f[i / CPB]));
      if ((i % CPB) == 2 && (i / CPB) >= 1 && (i / CPB) <= 8) dec[i / CPB - 1] = tx;
      if (i == drop_at) enable = 1'b0;
      if (i == rst_at) begin
        rst     = 1'b1;
        aborted = 1'b1;
      end
    end
    if (!aborted) begin
      check({nm, "_decoded"}, 32'(dec), 32'(exp_q.pop_front()));
      check({nm, "_no_early_done"}, 32'(done_cnt), 32'(d0));
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int rd0;
    int d0;
    int bad;

    vecs[0] = '{8'h2A, 10'b1_0010_1010_0};
    vecs[1] = '{8'h1E, 10'b1_0001_1110_0};
    vecs[2] = '{8'h37, 10'b1_0011_0111_0};
    vecs[3] = '{8'h57, 10'b1_0101_0111_0};
    vecs[4] = '{8'h00, 10'b1_0000_0000_0};
    vecs[5] = '{8'hFF, 10'b1_1111_1111_0};

    rst       = 1'b1;
    enable    = 1'b0;
    push_req  = 1'b0;
    push_data = 8'h00;

    // Reset held three cycles with an empty fifo.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_rd", 32'(fifo_rd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Single frames from the table.
    enable = 1'b1;
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(vecs[v].data);
      push(vecs[v].data);
      wait_rd($sformatf("vec%0d", v));
      rd0 = rd_cnt;
      frame_body(vecs[v].frame, $sformatf("vec%0d", v), -1, -1);
      tick();
      check("vec_done", 32'(tx_done), 32'd1);
      check("vec_idle_busy", 32'(busy), 32'd0);
      check("vec_idle_rd", 32'(fifo_rd), 32'd0);
      check("vec_one_pop", 32'(rd_cnt), 32'(rd0));
      tick();
      check("vec_done_1cyc", 32'(tx_done), 32'd0);
    end

    // Back-to-back 0x1E, 0x37.
    rd0 = rd_cnt;
    exp_q.push_back(8'h1E);
    exp_q.push_back(8'h37);
    push(8'h1E);
    push(8'h37);
    wait_rd("b2b_a");
    frame_body(10'b1_0001_1110_0, "b2b_a", -1, -1);
    tick();
    check("b2b_fetch_rd", 32'(fifo_rd), 32'd1);
    check("b2b_fetch_done", 32'(tx_done), 32'd1);
    check("b2b_fetch_tx", 32'(tx), 32'd1);
    frame_body(10'b1_0011_0111_0, "b2b_b", -1, -1);
    tick();
    check("b2b_done", 32'(tx_done), 32'd1);
    check("b2b_busy", 32'(busy), 32'd0);
    check("b2b_pops", 32'(rd_cnt - rd0), 32'd2);
    check("b2b_fifo_empty", 32'(fifo_cnt), 32'd0);

    // Enabled but empty: line must stay idle.
    rd0 = rd_cnt;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("empty_idle_bad", 32'(bad), 32'd0);
    check("empty_no_pop", 32'(rd_cnt), 32'(rd0));

    // Drop enable during data bit 3 (frame samples 16..19).
    rd0 = rd_cnt;
    exp_q.push_back(8'h57);
    push(8'h57);
    push(8'h57);
    wait_rd("drop");
    frame_body(10'b1_0101_0111_0, "drop", 4 * CPB + 1, -1);
    tick();
    check("drop_done", 32'(tx_done), 32'd1);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_rd", 32'(fifo_rd), 32'd0);
    for (int i = 0; i < 20; i++) tick();
    check("drop_one_pop", 32'(rd_cnt - rd0), 32'd1);
    check("drop_fifo_cnt", 32'(fifo_cnt), 32'd1);
    check("drop_idle_tx", 32'(tx), 32'd1);
    enable = 1'b1;
    exp_q.push_back(8'h57);
    wait_rd("drain");
    frame_body(10'b1_0101_0111_0, "drain", -1, -1);
    tick();
    check("drain_done", 32'(tx_done), 32'd1);
    check("drain_fifo_cnt", 32'(fifo_cnt), 32'd0);

    // Reset during data bit 5 (frame samples 24..27).
    push(8'h57);
    wait_rd("rstmid");
    d0 = done_cnt;
    frame_body(10'b1_0101_0111_0, "rstmid", -1, 6 * CPB + 1);
    tick();
    check("rstmid_tx", 32'(tx), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rd", 32'(fifo_rd), 32'd0);
    check("rstmid_done", 32'(tx_done), 32'd0);
    check("rstmid_state", 32'(dbg_state), 32'd0);
    tick();
    rst = 1'b0;
    rd0 = rd_cnt;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("rstmid_idle_bad", 32'(bad), 32'd0);
    check("rstmid_no_done", 32'(done_cnt), 32'(d0));
    check("rstmid_no_pop", 32'(rd_cnt), 32'(rd0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
